// File: rtl/vending_main.sv
// vending_main: six-product vending controller with purchase/restock transactions,
// a registered error vector with a sticky summary bit, and a red indicator lamp.
// Optional build macro: RESTOCK_SATURATE_EN (restock overflow clamps stock to 15).

// One product's stock counter; loads INIT_STOCK on reset.
module vending_stock_cell #(
    parameter int INIT_STOCK = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] din,
    output logic [3:0] q
);
    // Stock register: reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n)  q <= 4'(INIT_STOCK);
        else if (we) q <= din;
    end
endmodule

module vending_main #(
    parameter int INIT_STOCK = 5,
    parameter int NUM_TYPES  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [6:0] customer_money,
    input  logic [2:0] supply_type,
    input  logic [3:0] customer_amount,
    input  logic [3:0] amount_sypply_to_add,
    output logic [6:0] error,
    output logic       redLight
);
    localparam logic [3:0] NT = 4'(NUM_TYPES);

    logic [1:0]                  mode_q;
    logic                        trigger;
    logic                        txn;
    logic                        inv;
    logic [NUM_TYPES-1:0][3:0]   stock;
    logic [NUM_TYPES-1:0]        stock_we;
    logic [3:0]                  sel_stock;
    logic [3:0]                  stock_nxt;
    logic                        do_write;
    logic [4:0]                  price;
    logic [8:0]                  cost;
    logic [4:0]                  sum;
    logic [5:0]                  flags;

    // A transaction fires only on the cycle the mode changes into 1 or 2
    assign trigger = (mode != mode_q);
    assign txn     = trigger && (mode == 2'd1 || mode == 2'd2);
    assign inv     = ({1'b0, supply_type} >= NT);

    // Per-product stock storage
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TYPES; gi++) begin : g_stock
            assign stock_we[gi] = do_write && (supply_type == 3'(gi));
            vending_stock_cell #(.INIT_STOCK(INIT_STOCK)) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (stock_we[gi]),
                .din   (stock_nxt),
                .q     (stock[gi])
            );
        end
    endgenerate

    // Select the addressed product's stock; invalid codes read as zero
    always_comb begin
        sel_stock = '0;
        for (int i = 0; i < NUM_TYPES; i++)
            if (supply_type == 3'(i)) sel_stock = stock[i];
    end

    // Fixed price table; invalid codes price at zero (their cost check is suppressed anyway)
    always_comb begin
        case (supply_type)
            3'd0:    price = 5'd5;
            3'd1:    price = 5'd8;
            3'd2:    price = 5'd10;
            3'd3:    price = 5'd12;
            3'd4:    price = 5'd15;
            3'd5:    price = 5'd20;
            default: price = 5'd0;
        endcase
    end

    // Full-width cost (max 20*15=300) and 5-bit restock sum so nothing truncates
    assign cost = {4'b0, price} * {5'b0, customer_amount};
    assign sum  = {1'b0, sel_stock} + {1'b0, amount_sypply_to_add};

    // Evaluate all error flags in parallel and compute the stock update
    always_comb begin
        flags     = '0;
        do_write  = 1'b0;
        stock_nxt = sel_stock;
        if (trigger && mode == 2'd1) begin
            flags[0] = inv;
            flags[4] = (customer_amount == 4'd0);
            if (!inv) begin
                flags[1] = (customer_amount > sel_stock);
                flags[2] = ({2'b0, customer_money} < cost);
            end
            if (flags == 6'd0) begin
                do_write  = 1'b1;
                stock_nxt = sel_stock - customer_amount;
            end
        end else if (trigger && mode == 2'd2) begin
            flags[0] = inv;
            flags[5] = (amount_sypply_to_add == 4'd0);
`ifdef RESTOCK_SATURATE_EN
            if (flags == 6'd0) begin
                do_write  = 1'b1;
                stock_nxt = sum[4] ? 4'd15 : sum[3:0];
            end
`else
            if (!inv) flags[3] = sum[4];
            if (flags == 6'd0) begin
                do_write  = 1'b1;
                stock_nxt = sum[3:0];
            end
`endif
        end
    end

    // Mode history, error vector and lamp; mode 3 clears every cycle it is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= 2'd0;
            error    <= '0;
            redLight <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode == 2'd3) begin
                error    <= '0;
                redLight <= 1'b0;
            end else if (txn) begin
                error[5:0] <= flags;
                error[6]   <= error[6] | (|flags);
                redLight   <= |flags;
            end
        end
    end
endmodule

// File: tb/tb_vending_main.sv
// Scoreboard bench for vending_main: the stimulus process pushes the hand-computed
// error/lamp expected after each clock; a monitor pops and compares on the falling edge.
module tb_vending_main;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [6:0] customer_money;
    logic [2:0] supply_type;
    logic [3:0] customer_amount;
    logic [3:0] amount_sypply_to_add;
    logic [6:0] error;
    logic       redLight;

    typedef struct {
        int         id;
        logic [6:0] err;
        logic       red;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;
    bit   stim_done = 1'b0;

    vending_main dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mode                 (mode),
        .customer_money       (customer_money),
        .supply_type          (supply_type),
        .customer_amount      (customer_amount),
        .amount_sypply_to_add (amount_sypply_to_add),
        .error                (error),
        .redLight             (redLight)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then queue the response expected after that posedge
    task automatic step(input logic r, input logic [1:0] m, input logic [2:0] t,
                        input logic [3:0] amt, input logic [6:0] money,
                        input logic [3:0] add, input logic [6:0] e_err, input logic e_red);
        exp_t e;
        @(negedge clk);
        rst_n = r; mode = m; supply_type = t; customer_amount = amt;
        customer_money = money; amount_sypply_to_add = add;
        @(posedge clk);
        step_id++;
        e.id = step_id; e.err = e_err; e.red = e_red;
        exp_q.push_back(e);
    endtask

    // Shorthands: purchase, restock, plain mode with no operands
    task automatic buy(input logic [2:0] t, input logic [3:0] amt, input logic [6:0] money,
                       input logic [6:0] e_err, input logic e_red);
        step(1'b1, 2'd1, t, amt, money, 4'd0, e_err, e_red);
    endtask
    task automatic fill(input logic [2:0] t, input logic [3:0] add,
                        input logic [6:0] e_err, input logic e_red);
        step(1'b1, 2'd2, t, 4'd0, 7'd0, add, e_err, e_red);
    endtask
    task automatic idle(input logic [1:0] m, input logic [6:0] e_err, input logic e_red);
        step(1'b1, m, 3'd0, 4'd0, 7'd0, 4'd0, e_err, e_red);
    endtask

    // Monitor: outputs are registered and stable at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (error !== e.err || redLight !== e.red) begin
                    fails++;
                    $display("FAIL step%0d: error=%b redLight=%b, expected error=%b redLight=%b",
                             e.id, error, redLight, e.err, e.red);
                end
            end
        end
    end

    // Stimulus: directed vectors
    initial begin
        rst_n = 1'b0; mode = 2'd0; supply_type = '0; customer_amount = '0;
        customer_money = '0; amount_sypply_to_add = '0;

        // Reset state
        step(1'b0, 2'd0, 3'd0, 4'd0, 7'd0, 4'd0, 7'b0000000, 1'b0);
        step(1'b0, 2'd0, 3'd0, 4'd0, 7'd0, 4'd0, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);

        // Insufficient money; lamp and sticky bit set, then held, then cleared
        buy(3'd0, 4'd1, 7'd0, 7'b1000100, 1'b1);
        idle(2'd0, 7'b1000100, 1'b1);
        idle(2'd3, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);

        // Exact-money purchase of 3 x type 2 (cost 30); holding mode 1 must not repeat it
        buy(3'd2, 4'd3, 7'd30, 7'b0000000, 1'b0);
        buy(3'd2, 4'd3, 7'd30, 7'b0000000, 1'b0);
        buy(3'd2, 4'd3, 7'd30, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);
        // Stock 2 is now 2: buying 3 fails, buying 2 empties it (not an error)
        buy(3'd2, 4'd3, 7'd127, 7'b1000010, 1'b1);
        idle(2'd0, 7'b1000010, 1'b1);
        buy(3'd2, 4'd2, 7'd127, 7'b1000000, 1'b0);
        idle(2'd0, 7'b1000000, 1'b0);
        buy(3'd2, 4'd1, 7'd127, 7'b1000010, 1'b1);
        idle(2'd3, 7'b0000000, 1'b0);

        // Over-stock request on type 1, clear held over two cycles, stock 1 still 5
        buy(3'd1, 4'd6, 7'd127, 7'b1000010, 1'b1);
        idle(2'd3, 7'b0000000, 1'b0);
        idle(2'd3, 7'b0000000, 1'b0);
        buy(3'd1, 4'd5, 7'd40, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);

        // Zero amount, and two flags together (6 > 5 stock, cost 120 > 10)
        buy(3'd5, 4'd0, 7'd0, 7'b1010000, 1'b1);
        idle(2'd0, 7'b1010000, 1'b1);
        buy(3'd5, 4'd6, 7'd10, 7'b1000110, 1'b1);
        idle(2'd3, 7'b0000000, 1'b0);

        // Restock overflow boundary on type 4
`ifdef RESTOCK_SATURATE_EN
        fill(3'd4, 4'd11, 7'b0000000, 1'b0);
        idle(2'd3, 7'b0000000, 1'b0);
        fill(3'd4, 4'd10, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);
        fill(3'd4, 4'd1, 7'b0000000, 1'b0);
`else
        fill(3'd4, 4'd11, 7'b1001000, 1'b1);
        idle(2'd3, 7'b0000000, 1'b0);
        fill(3'd4, 4'd10, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);
        fill(3'd4, 4'd1, 7'b1001000, 1'b1);
`endif
        idle(2'd3, 7'b0000000, 1'b0);

        // Invalid type on purchase, zero restock, invalid restock, invalid purchase
        buy(3'd7, 4'd1, 7'd100, 7'b1000001, 1'b1);
        fill(3'd3, 4'd0, 7'b1100000, 1'b1);
        fill(3'd3, 4'd0, 7'b1100000, 1'b1);
        idle(2'd0, 7'b1100000, 1'b1);
        fill(3'd6, 4'd3, 7'b1000001, 1'b1);
        buy(3'd6, 4'd6, 7'd0, 7'b1000001, 1'b1);
        idle(2'd0, 7'b1000001, 1'b1);

        // Reset asserted during a triggered purchase wins; stocks reload
        step(1'b0, 2'd1, 3'd0, 4'd5, 7'd127, 4'd0, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);
        buy(3'd2, 4'd5, 7'd50, 7'b0000000, 1'b0);
        idle(2'd0, 7'b0000000, 1'b0);
        buy(3'd2, 4'd1, 7'd10, 7'b1000010, 1'b1);
        idle(2'd0, 7'b1000010, 1'b1);
        buy(3'd0, 4'd5, 7'd25, 7'b1000000, 1'b0);
        idle(2'd0, 7'b1000000, 1'b0);

        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise
    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
